// File: rtl/memory_arbiter_if.sv
// Bundle of requester, shared-RAM and status signals around the memory arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM side.
interface memory_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic        datomic;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one RAM port,
// with alternating priority under contention and LL/SC link tracking.
module memory_arbiter #(
  parameter logic [31:0] RAM_ERR_DATA = 32'hBAD1BAD1
) (
  input logic              CLK,
  input logic              nRST,
  memory_arbiter_if.slave  bus
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IREQ   = 2'd1,
    DREQ   = 2'd2,
    SCFAIL = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            last_d_q, last_d_d;
  logic            link_valid_q, link_valid_d;
  logic [AW-1:0]   link_addr_q, link_addr_d;
  logic            err_q, err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   store_q, store_d;
  logic            wr_q, wr_d;
  logic            atomic_q, atomic_d;

  logic ram_done_c, ram_err_c, grant_d_c, link_hit_c;

  assign ram_done_c = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);
  assign ram_err_c  = (bus.ramstate == RAM_ERROR);
  // Data wins when it is the only requester or when fetch was served last.
  assign grant_d_c  = (bus.dREN || bus.dWEN) && (!bus.iREN || !last_d_q);
  assign link_hit_c = link_valid_q && (bus.daddr == link_addr_q);
  assign bus.err    = err_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_d_q     <= 1'b0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
      err_q        <= 1'b0;
      addr_q       <= '0;
      store_q      <= '0;
      wr_q         <= 1'b0;
      atomic_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_d_q     <= last_d_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
      err_q        <= err_d;
      addr_q       <= addr_d;
      store_q      <= store_d;
      wr_q         <= wr_d;
      atomic_q     <= atomic_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d_d     = last_d_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    err_d        = err_q;
    addr_d       = addr_q;
    store_d      = store_q;
    wr_d         = wr_q;
    atomic_d     = atomic_q;
    case (state_q)
      IDLE: begin
        if (grant_d_c) begin
          addr_d   = bus.daddr;
          store_d  = bus.dstore;
          wr_d     = bus.dWEN;
          atomic_d = bus.datomic;
          if (bus.dWEN && bus.datomic) begin
            link_valid_d = 1'b0;
            state_d      = link_hit_c ? DREQ : SCFAIL;
          end else begin
            state_d = DREQ;
          end
        end else if (bus.iREN) begin
          addr_d   = bus.iaddr;
          store_d  = '0;
          wr_d     = 1'b0;
          atomic_d = 1'b0;
          state_d  = IREQ;
        end
      end
      IREQ: begin
        if (ram_done_c) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
          err_d    = err_q || ram_err_c;
        end
      end
      DREQ: begin
        if (ram_done_c) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
          err_d    = err_q || ram_err_c;
          if (!wr_q && atomic_q) begin
            link_valid_d = 1'b1;
            link_addr_d  = addr_q;
          end else if (wr_q && !atomic_q && (addr_q == link_addr_q)) begin
            link_valid_d = 1'b0;
          end
        end
      end
      SCFAIL: begin
        state_d  = IDLE;
        last_d_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM side decodes from registers only; wait/load follow ramstate in the completion cycle.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    bus.dwait    = 1'b1;
    bus.dload    = '0;
    case (state_q)
      IREQ: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = addr_q;
        if (ram_done_c) begin
          bus.iwait = 1'b0;
          bus.iload = ram_err_c ? RAM_ERR_DATA : bus.ramload;
        end
      end
      DREQ: begin
        bus.ramREN   = !wr_q;
        bus.ramWEN   = wr_q;
        bus.ramaddr  = addr_q;
        bus.ramstore = store_q;
        if (ram_done_c) begin
          bus.dwait = 1'b0;
          if (ram_err_c)             bus.dload = RAM_ERR_DATA;
          else if (wr_q && atomic_q) bus.dload = DW'(1);
          else                       bus.dload = bus.ramload;
        end
      end
      SCFAIL: bus.dwait = 1'b0;
      default: ;
    endcase
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter: RAM_ERR_DATA, default 32'hBAD1BAD1, word returned to a requester whose RAM access ends in ERROR.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of CLK.
REQ-003 Port: CLK  in  1  system clock.
REQ-004 Port: nRST  in  1  asynchronous reset, active low.
REQ-005 Port: iREN  in  1  instruction fetch request; iaddr  in  32  fetch address.
REQ-006 Port: iwait  out  1  low for exactly the completion cycle of a fetch; iload  out  32  fetched word, valid when iwait=0.
REQ-007 Port: dREN  in  1  data read request; dWEN  in  1  data write request; datomic  in  1  qualifies dREN as LL and dWEN as SC.
REQ-008 Port: daddr  in  32  data address; dstore  in  32  write data.
REQ-009 Port: dwait  out  1  low for exactly the completion cycle of a data access; dload  out  32  read word or SC result, valid when dwait=0.
REQ-010 Port: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32; these form the single shared RAM port.
REQ-011 Port: ramload  in  32  RAM read data; ramstate  in  2  RAM state, encoded FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-012 Port: err  out  1  sticky RAM-error flag.

Function
REQ-013 The FSM SHALL have states IDLE, IREQ, DREQ and SCFAIL.
REQ-014 In IDLE the block SHALL drive no RAM request and SHALL hold iwait=1 and dwait=1.
REQ-015 Grant in IDLE: data pending = dREN|dWEN.
  - Only one side pending: grant that side.
  - Both pending: grant the side not served last (last-served register, reset value I).
  - Nothing pending: stay in IDLE.
REQ-016 On grant, the block SHALL latch address, store data, operation (read/write) and atomic bit.
  - The next state SHALL be IREQ or DREQ, or SCFAIL for an SC whose link check fails.
REQ-017 dREN and dWEN both high SHALL be treated as a write.
REQ-018 In IREQ the block SHALL drive ramREN=1 and ramaddr=latched iaddr.
REQ-019 In DREQ the block SHALL drive ramREN or ramWEN (never both), ramaddr=latched daddr, and ramstore=latched dstore.
REQ-020 While ramstate is FREE or BUSY, the block SHALL stay in the current state.
REQ-021 In the cycle ramstate=ACCESS:
  - the granted wait SHALL be 0 and the granted load SHALL be ramload (dload=1 for a successful SC);
  - the next state SHALL be IDLE and last-served SHALL update.
REQ-022 ramstate=ERROR SHALL complete the access as in REQ-021, except that load=RAM_ERR_DATA and err is set until reset.
REQ-023 Minimum latency SHALL be 2 cycles from a request sampled in IDLE to its wait-low cycle (RAM ACCESS on the first request cycle).
REQ-024 Back-to-back: a request still asserted in the cycle after completion SHALL be arbitrated again from IDLE.
  - Requesters SHALL drop the request on the completion cycle to avoid a repeat.
REQ-025 A request deasserted mid-access SHALL NOT abort the RAM transaction; it completes and the result is discarded.
REQ-026 Link register (valid, 32-bit addr), maintained by data accesses:
  - LL completion SHALL set valid=1 and addr=latched daddr.
  - A non-atomic write completion whose address equals the link addr SHALL clear valid.
  - Any SC grant SHALL clear valid.
REQ-027 SC grant with link valid and address equal to the link addr SHALL go to DREQ as a write, returning dload=32'h1 on completion.
REQ-028 SC grant with the link invalid or the address different SHALL go to SCFAIL.
  - SCFAIL: no RAM request, dwait=0, dload=32'h0 for one cycle, then IDLE.
REQ-029 An instruction fetch SHALL NOT affect the link register.
REQ-030 RAM outputs SHALL decode from the state register and latched values only; they SHALL be glitch-free with respect to requester inputs.

Reset
REQ-031 While nRST=0, the block SHALL immediately force:
  - state=IDLE, last-served=I, link valid=0, link addr=0, err=0;
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0;
  - iwait=1, dwait=1, iload=0, dload=0.
REQ-032 Reset asserted mid-access SHALL abandon the access with no completion pulse.
  - The first cycle after reset release SHALL be IDLE.

Verification
REQ-033 Single fetch: iREN=1 with iaddr=0x40, RAM BUSY 2 cycles then ACCESS with ramload=0x8C010004 -> ramREN=1 and ramaddr=0x40 for 3 cycles; iwait=0 and iload=0x8C010004 in the ACCESS cycle only.
REQ-034 Contention: iREN and dREN held high from reset -> grant order D, I, D, I; each grant gets exactly one wait-low pulse; ramWEN stays 0.
REQ-035 LL/SC success: LL 0x100, then SC 0x100 with dstore=0x5 -> ramWEN=1, ramstore=5, dload=1; a second SC 0x100 -> SCFAIL, dload=0, no RAM request.
REQ-036 LL/SC broken: LL 0x200, then a plain SW to 0x200, then SC 0x200 -> SC fails with dload=0; a plain SW to 0x204 instead leaves the SC successful.
REQ-037 Error and reset: ramstate=ERROR on a read -> dload=0xBAD1BAD1 and err=1 sticky; nRST pulsed low mid-DREQ -> ram outputs 0 asynchronously, err=0, no dwait pulse.
